// File: rtl/nibble_pkg.sv
// Shared types and defaults for the nibble collector and its upstream shift-register stage.
package nibble_pkg;

   localparam int unsigned NIB_W_DEF = 4;
   localparam int unsigned DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLD    = 2'd3
   } state_e;

   // Counter width for a given depth; at least one bit so DEPTH=1 still has a counter.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/nibble_collector_cap_counter.sv
// Capture counter: sync clear, enable, saturates at LAST and flags it.
module cap_counter #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned LAST  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o,
   output logic             term_c
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   assign term_c  = (cnt_q == WIDTH'(LAST));
   assign count_o = cnt_q;

   // Next count: clear wins, otherwise count up and stop at the terminal value.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !term_c) begin
         cnt_d = cnt_q + WIDTH'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/nibble_collector.sv
// Collects DEPTH nibbles from an upstream shift register into one word and
// offers it on a valid/ready handshake.
module nibble_collector
   import nibble_pkg::*;
#(
   parameter int unsigned NIB_W = NIB_W_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [NIB_W-1:0]       ser_in,
   output logic                   load,
   output logic [NIB_W*DEPTH-1:0] word,
   output logic                   valid,
   input  logic                   ready,
   output logic                   busy
);

   localparam int unsigned CNT_W  = cnt_width(DEPTH);
   localparam int unsigned WORD_W = NIB_W * DEPTH;

   state_e              state_q;
   state_e              state_d;
   logic                load_q;
   logic                load_d;
   logic                valid_q;
   logic                valid_d;
   logic                busy_q;
   logic                busy_d;
   logic [WORD_W-1:0]   word_q;
   logic [WORD_W-1:0]   word_d;
   logic                cnt_clr;
   logic                cnt_en;
   logic [CNT_W-1:0]    cnt;
   logic                cnt_last_c;

   // Nibble position counter for the CAPTURE phase.
   cap_counter #(
      .WIDTH (CNT_W),
      .LAST  (DEPTH - 1)
   ) u_cap_counter (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (cnt_clr),
      .en_i    (cnt_en),
      .count_o (cnt),
      .term_c  (cnt_last_c)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start is only looked at in IDLE and on the handshake cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (cnt_last_c) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (ready) state_d = start ? ST_LOAD : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output and datapath next values; Moore outputs are decoded from the next state
   // so the registered copies line up with the state they belong to.
   always_comb begin
      load_d  = (state_d == ST_LOAD);
      valid_d = (state_d == ST_HOLD);
      busy_d  = (state_d != ST_IDLE);
      cnt_clr = (state_q == ST_LOAD);
      cnt_en  = (state_q == ST_CAPTURE);
      word_d  = word_q;
      if (state_q == ST_CAPTURE) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if (cnt == CNT_W'(k)) begin
               word_d[k*NIB_W +: NIB_W] = ser_in;
            end
         end
      end
   end

   // Output and word registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         word_q  <= '0;
      end else begin
         load_q  <= load_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         word_q  <= word_d;
      end
   end

   assign load  = load_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign word  = word_q;

endmodule

// File: tb/tb_nibble_collector.sv
// Directed bench for nibble_collector with a behavioural upstream shift register.
module tb_nibble_collector;
   import nibble_pkg::*;

   localparam int unsigned NIB_W  = NIB_W_DEF;
   localparam int unsigned DEPTH  = DEPTH_DEF;
   localparam int unsigned WORD_W = NIB_W * DEPTH;

   logic              clk;
   logic              reset;
   logic              start;
   logic              ready;
   logic              load;
   logic              valid;
   logic              busy;
   logic [NIB_W-1:0]  ser_in;
   logic [WORD_W-1:0] word;

   logic [NIB_W-1:0]  d_par [DEPTH];
   logic [NIB_W-1:0]  sr_q  [DEPTH];

   int vectors;
   int miscompares;

   nibble_collector #(
      .NIB_W (NIB_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .ser_in (ser_in),
      .load   (load),
      .word   (word),
      .valid  (valid),
      .ready  (ready),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Upstream shift register: parallel load on load, otherwise shift toward sout.
   always_ff @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < DEPTH; i++) sr_q[i] <= d_par[i];
      end else begin
         for (int i = 0; i < DEPTH - 1; i++) sr_q[i] <= sr_q[i+1];
         sr_q[DEPTH-1] <= '0;
      end
   end
   assign ser_in = sr_q[0];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic set_data(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
      d_par[0] = a;
      d_par[1] = b;
      d_par[2] = c;
      d_par[3] = d;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      start       = 1'b0;
      ready       = 1'b0;
      reset       = 1'b1;
      set_data(4'h0, 4'h0, 4'h0, 4'h0);
      #2 reset = 1'b0;
      #1;
      chk("rst_load",  32'(load),  32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_busy",  32'(busy),  32'h0);
      chk("rst_word",  32'(word),  32'h0);
      step();
      @(negedge clk) reset = 1'b1;

      // Single word, ready already high
      set_data(4'h1, 4'h2, 4'h3, 4'h4);
      ready = 1'b1;
      start = 1'b1;
      step();
      chk("t1_load",  32'(load),  32'h1);
      chk("t1_busy",  32'(busy),  32'h1);
      chk("t1_valid", 32'(valid), 32'h0);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t1_cap_load",  32'(load),  32'h0);
         chk("t1_cap_valid", 32'(valid), 32'h0);
         chk("t1_cap_busy",  32'(busy),  32'h1);
      end
      step();
      chk("t1_valid6", 32'(valid), 32'h1);
      chk("t1_word",   32'(word),  32'h4321);
      step();
      chk("t1_idle_valid", 32'(valid), 32'h0);
      chk("t1_idle_busy",  32'(busy),  32'h0);
      chk("t1_idle_load",  32'(load),  32'h0);

      // Consumer stalls for 5 cycles
      ready = 1'b0;
      start = 1'b1;
      step();
      chk("t2_load", 32'(load), 32'h1);
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      step();
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_valid", 32'(valid), 32'h1);
         chk("t2_hold_word",  32'(word),  32'h4321);
         step();
      end
      chk("t2_ready_valid", 32'(valid), 32'h1);
      ready = 1'b1;
      step();
      chk("t2_rel_valid", 32'(valid), 32'h0);
      chk("t2_rel_busy",  32'(busy),  32'h0);

      // start held high: back-to-back words
      set_data(4'hA, 4'hB, 4'hC, 4'hD);
      start = 1'b1;
      for (int c = 0; c < 18; c++) begin
         step();
         chk("t3_load",  32'(load),  32'((c % 6) == 0));
         chk("t3_valid", 32'(valid), 32'((c % 6) == 5));
         chk("t3_busy",  32'(busy),  32'h1);
         if ((c % 6) == 5) chk("t3_word", 32'(word), 32'hDCBA);
         if (c == 17) start = 1'b0;
      end
      step();
      chk("t3_end_busy",  32'(busy),  32'h0);
      chk("t3_end_load",  32'(load),  32'h0);

      // start pulses during CAPTURE are ignored
      set_data(4'h5, 4'h6, 4'h7, 4'h8);
      start = 1'b1;
      step();
      chk("t4_load", 32'(load), 32'h1);
      start = 1'b0;
      step();
      chk("t4_busy0", 32'(busy), 32'h1);
      start = 1'b1;
      step();
      chk("t4_busy1", 32'(busy), 32'h1);
      chk("t4_load1", 32'(load), 32'h0);
      start = 1'b0;
      step();
      chk("t4_busy2", 32'(busy), 32'h1);
      start = 1'b1;
      step();
      chk("t4_busy3", 32'(busy), 32'h1);
      chk("t4_load3", 32'(load), 32'h0);
      start = 1'b0;
      step();
      chk("t4_valid", 32'(valid), 32'h1);
      chk("t4_word",  32'(word),  32'h8765);
      step();
      chk("t4_idle_busy", 32'(busy), 32'h0);
      step();
      chk("t4_noq_load", 32'(load), 32'h0);
      chk("t4_noq_busy", 32'(busy), 32'h0);

      // Asynchronous reset in the 2nd CAPTURE cycle
      set_data(4'h9, 4'hA, 4'hB, 4'hC);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      chk("t5_partial", 32'(word), 32'h8769);
      #3 reset = 1'b0;
      #1;
      chk("t5_async_load",  32'(load),  32'h0);
      chk("t5_async_valid", 32'(valid), 32'h0);
      chk("t5_async_busy",  32'(busy),  32'h0);
      chk("t5_async_word",  32'(word),  32'h0);
      step();
      chk("t5_held_busy", 32'(busy), 32'h0);
      @(negedge clk) reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("t5_post_valid", 32'(valid), 32'h0);
         chk("t5_post_busy",  32'(busy),  32'h0);
      end

      // start together with reset release is taken at the first edge
      @(negedge clk) reset = 1'b0;
      @(negedge clk) begin
         reset = 1'b1;
         start = 1'b1;
      end
      step();
      chk("t6_load", 32'(load), 32'h1);
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      step();
      chk("t6_valid", 32'(valid), 32'h1);
      chk("t6_word",  32'(word),  32'hCBA9);
      step();
      chk("t6_idle", 32'(busy), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/nibble_collector.md
NIBBLE_COLLECTOR -- requirements
Module: nibble_collector

Interface
REQ-001 SHALL have parameter NIB_W, default 4, giving the nibble width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, giving the nibbles per word (the upstream shift-register stage count).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request one word collection.
REQ-006 SHALL have port ser_in  input  NIB_W  serial nibble from the upstream shift-register sout.
REQ-007 SHALL have port load  output  1  parallel-load select driven to the upstream shift register.
REQ-008 SHALL have port word  output  NIB_W*DEPTH  assembled word.
REQ-009 SHALL have port valid  output  1  word is valid.
REQ-010 SHALL have port ready  input  1  consumer accepts word.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, CAPTURE, HOLD; all outputs Moore and registered.
REQ-013 IDLE: start=1 SHALL move the FSM to LOAD; start=0 SHALL keep it in IDLE.
REQ-014 LOAD SHALL last exactly one cycle with load=1, then move to CAPTURE with the capture count at 0.
REQ-015 load SHALL be 0 in every state other than LOAD.
REQ-016 CAPTURE SHALL last exactly DEPTH cycles and sample ser_in at the end of each cycle.
REQ-017 Capture number k (k=0..DEPTH-1) SHALL be written to word[k*NIB_W +: NIB_W], so the first nibble out (d0) lands in the LSBs.
REQ-018 The capture counter SHALL be ceil(log2(DEPTH)) bits wide and SHALL leave CAPTURE when count==DEPTH-1; it SHALL NOT wrap.
REQ-019 HOLD: valid=1 and word SHALL be stable until valid&ready.
REQ-020 Handshake: valid SHALL NOT drop without ready.
REQ-021 On the valid&ready cycle, start=1 SHALL move the FSM directly to LOAD (back-to-back); start=0 SHALL move it to IDLE.
REQ-022 start SHALL be ignored in LOAD and CAPTURE, and in HOLD when ready=0; ignored starts SHALL NOT be queued.
REQ-023 Latency: start sampled at edge N SHALL give load=1 in cycle N+1 and valid=1 from cycle N+1+DEPTH+1 (cycle 6 for DEPTH=4).
REQ-024 word SHALL retain its last value in IDLE; it is meaningful only while valid=1.
REQ-025 ready while valid=0 SHALL have no effect.

Reset
REQ-026 reset=0 SHALL, asynchronously: set the state to IDLE, load=0, valid=0, busy=0, the counter to 0, and word to 0.
REQ-027 Reset mid-CAPTURE or mid-HOLD SHALL discard the partial or pending word; no valid pulse SHALL follow the release of reset.
REQ-028 The first start after reset release SHALL be honoured at the first rising edge with reset=1.

Structure
REQ-029 The state encoding and the NIB_W/DEPTH defaults SHALL live in the shared package nibble_pkg, reused by the shift-register stage and the bench.
REQ-030 The capture counter SHALL be a sub-module, cap_counter (sync clear, enable, terminal-count flag); FSM and word register stay in nibble_collector.

Verification
REQ-031 Upstream register loaded with d0..d3=1,2,3,4, start pulse, ready=1 -> load high one cycle, valid in cycle 6, word=16'h4321, then IDLE.
REQ-032 Same stimulus with ready held 0 for 5 cycles after valid -> valid and word=16'h4321 stable 5 cycles; released on the ready cycle.
REQ-033 start held 1 continuously, d=A,B,C,D, ready=1 -> words 16'hDCBA back-to-back; valid-to-load gap 0 cycles; load every 6 cycles.
REQ-034 start pulses during CAPTURE -> ignored; exactly one word produced; busy high throughout.
REQ-035 reset=0 asserted in the 2nd CAPTURE cycle -> outputs 0 immediately (asynchronous); after release no valid until a new start.
